// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, instruction field positions, FSM states and decode helpers shared by the sequencer and the ALU.
// Latency: none. This file holds types and constants only.
// Backpressure: none.
// Contents:
//   DATA_W / NUM_REGS / REG_AW / INSTR_W - datapath, register-file and instruction geometry
//   OP_LOAD..OP_DISPLAY                  - 3-bit opcodes carried in instr[15:13] and on alu_param
//   *_MSB / *_LSB                        - instruction field positions
//   state_t                              - sequencer FSM states
//   instr_t / decode_instr()             - decoded instruction fields with sign-extended immediates
package ula_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = $clog2(NUM_REGS);
  localparam int INSTR_W  = 16;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_LOAD    = 3'b000;
  localparam opcode_t OP_ADD     = 3'b001;
  localparam opcode_t OP_ADDI    = 3'b010;
  localparam opcode_t OP_SUB     = 3'b011;
  localparam opcode_t OP_SUBI    = 3'b100;
  localparam opcode_t OP_MUL     = 3'b101;
  localparam opcode_t OP_CLEAR   = 3'b110;
  localparam opcode_t OP_DISPLAY = 3'b111;

  // Instruction field positions.
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 13;
  localparam int RD_MSB    = 12;
  localparam int RD_LSB    = 10;
  localparam int RS1_MSB   = 9;
  localparam int RS1_LSB   = 7;
  localparam int RS2_MSB   = 6;
  localparam int RS2_LSB   = 4;
  localparam int IMM7_MSB  = 6;
  localparam int IMM10_MSB = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  typedef struct packed {
    opcode_t             op;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [DATA_W-1:0]   imm7;   // sign-extended instr[6:0]
    logic [DATA_W-1:0]   imm10;  // sign-extended instr[9:0]
  } instr_t;

  // Split an instruction word into its fields. The rs2 and imm7 fields
  // overlap; every opcode uses at most one of them.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.op    = w[OP_MSB:OP_LSB];
    d.rd    = w[RD_MSB:RD_LSB];
    d.rs1   = w[RS1_MSB:RS1_LSB];
    d.rs2   = w[RS2_MSB:RS2_LSB];
    d.imm7  = {{(DATA_W-IMM7_MSB-1){w[IMM7_MSB]}}, w[IMM7_MSB:0]};
    d.imm10 = {{(DATA_W-IMM10_MSB-1){w[IMM10_MSB]}}, w[IMM10_MSB:0]};
    return d;
  endfunction

  // LOAD through MUL write their result to rd. CLEAR and DISPLAY do not.
  function automatic logic writes_rd(input opcode_t op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/ula_regfile.sv
// ula_regfile: NUM_REGS x DATA_W register file with two async read ports, one sync write port and a clear-all.
// Latency: reads are combinational; a write or clear is visible the cycle after the edge that performs it.
// Backpressure: none. A write is taken on every edge where we=1.
// Ports:
//   clk, rst_n      - clock and synchronous active-low reset (clears every register)
//   raddr1/rdata1   - read port 1 (asynchronous)
//   raddr2/rdata2   - read port 2 (asynchronous)
//   we/waddr/wdata  - synchronous write port
//   clr             - zeroes every register in one cycle; takes priority over we
module ula_regfile #(
  parameter int DATA_W   = ula_pkg::DATA_W,
  parameter int NUM_REGS = ula_pkg::NUM_REGS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1,
  output logic [DATA_W-1:0]           rdata1,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2,
  output logic [DATA_W-1:0]           rdata2,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        clr
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  // Reset and clear share one path. Reset also wins over a write-back
  // that is still in flight, so the write-back is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/ula_ctrl.sv
// ula_ctrl: instruction sequencer feeding the 16-bit ALU, with register-file write-back and a display output.
// Latency: handshake in cycle T -> done and display_valid in T+3 -> instr_ready again in T+4 (one instruction per 4 cycles).
// Backpressure: instr_ready is high only in IDLE. instr_valid seen in any other state is ignored, not queued.
// Ports:
//   clk, rst_n                   - clock and synchronous active-low reset
//   instr/instr_valid/instr_ready - instruction input handshake
//   alu_a/alu_b/alu_param        - registered ALU operands and opcode
//   alu_s                        - combinational ALU result
//   done                         - one-cycle pulse when an instruction retires
//   display_value/display_valid  - last DISPLAY value and its one-cycle update pulse
module ula_ctrl #(
  parameter int DATA_W   = ula_pkg::DATA_W,
  parameter int NUM_REGS = ula_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_param,
  input  logic [DATA_W-1:0] alu_s,
  output logic              done,
  output logic [DATA_W-1:0] display_value,
  output logic              display_valid
);

  import ula_pkg::*;

  state_t             state;
  logic [15:0]        instr_q;
  logic [DATA_W-1:0]  result;
  instr_t             dec;
  logic [DATA_W-1:0]  rdata1;
  logic [DATA_W-1:0]  rdata2;
  logic [DATA_W-1:0]  opnd_a;
  logic [DATA_W-1:0]  opnd_b;
  logic               rf_we;
  logic               rf_clr;

  // The latched instruction stays decoded until the next handshake, so
  // DECODE (operand read) and WB (write-back target) both use it.
  assign dec = decode_instr(instr_q);

  assign instr_ready = (state == ST_IDLE);

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  assign rf_we  = (state == ST_WB) && writes_rd(dec.op);
  assign rf_clr = (state == ST_WB) && (dec.op == OP_CLEAR);

  ula_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (dec.rs1),
    .rdata1 (rdata1),
    .raddr2 (dec.rs2),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (dec.rd),
    .wdata  (result),
    .clr    (rf_clr)
  );

  // ---------------------------------------------------------------------
  // Operand select. This is registered into alu_a/alu_b at the end of
  // DECODE. The ALU applies alu_param, so the muxing here only decides
  // what each operand is.
  // ---------------------------------------------------------------------
  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    case (dec.op)
      OP_LOAD: begin
        opnd_b = dec.imm10;
      end
      OP_ADD, OP_SUB, OP_MUL: begin
        opnd_a = rdata1;
        opnd_b = rdata2;
      end
      OP_ADDI, OP_SUBI: begin
        opnd_a = rdata1;
        opnd_b = dec.imm7;
      end
      OP_CLEAR: begin
        opnd_a = '0;
        opnd_b = '0;
      end
      OP_DISPLAY: begin
        opnd_a = rdata1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM. All outputs except instr_ready are registered here.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      instr_q       <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_param     <= OP_LOAD;
      result        <= '0;
      done          <= 1'b0;
      display_value <= '0;
      display_valid <= 1'b0;
    end else begin
      done          <= 1'b0;
      display_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_a     <= opnd_a;
          alu_b     <= opnd_b;
          alu_param <= dec.op;
          state     <= ST_EXEC;
        end
        ST_EXEC: begin
          result <= alu_s;
          // done and the display update are raised on the EXEC->WB edge.
          // Because they are registered, they are visible during the WB
          // cycle, together with the write-back.
          done <= 1'b1;
          if (dec.op == OP_DISPLAY) begin
            display_value <= alu_s;
            display_valid <= 1'b1;
          end
          state <= ST_WB;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: self-checking bench for ula_ctrl, with a behavioural ALU and a reference register model.
// Latency: not applicable.
// Backpressure: instructions are offered with instr_valid and held until instr_ready is seen.
module tb_ula_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_param;
  logic [15:0] alu_s;
  logic        done;
  logic [15:0] display_value;
  logic        display_valid;

  always #5 clk = ~clk;

  ula_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_param     (alu_param),
    .alu_s         (alu_s),
    .done          (done),
    .display_value (display_value),
    .display_valid (display_valid)
  );

  // Behavioural 16-bit ALU.
  logic [31:0] prod;
  assign prod = {16'b0, alu_a} * {16'b0, alu_b};

  always_comb begin
    alu_s = '0;
    case (alu_param)
      3'd0, 3'd1, 3'd2: alu_s = alu_a + alu_b;
      3'd3, 3'd4:       alu_s = alu_a - alu_b;
      3'd5:             alu_s = prod[15:0];
      3'd6:             alu_s = '0;
      default:          alu_s = alu_a;
    endcase
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_sent = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: architectural register values and expected outputs.
  typedef struct {
    int         t;
    logic [2:0] op;
  } exp_t;

  logic [15:0] mregs [8];
  exp_t        done_q[$];
  logic [15:0] disp_q[$];

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  task automatic model_issue(input logic [15:0] w, input int t);
    int op  = int'(w[15:13]);
    int rd  = int'(w[12:10]);
    int rs1 = int'(w[9:7]);
    int rs2 = int'(w[6:4]);
    int x   = sx(int'(mregs[rs1]), 16);
    int y   = sx(int'(mregs[rs2]), 16);
    int i7  = sx(int'(w[6:0]), 7);
    int i10 = sx(int'(w[9:0]), 10);
    int r   = 0;
    exp_t e;
    case (op)
      0: r = i10;
      1: r = x + y;
      2: r = x + i7;
      3: r = x - y;
      4: r = x - i7;
      5: r = x * y;
      default: r = 0;
    endcase
    if (op <= 5) begin
      mregs[rd] = r[15:0];
    end else if (op == 6) begin
      foreach (mregs[i]) mregs[i] = '0;
    end else begin
      disp_q.push_back(mregs[rs1]);
    end
    e.t  = t;
    e.op = w[15:13];
    done_q.push_back(e);
    n_sent++;
  endtask

  // Monitor: pops an expectation whenever the DUT raises done or display_valid.
  always @(negedge clk) begin
    exp_t e;
    if (display_valid === 1'b1) begin
      if (disp_q.size() == 0) chk("display_valid_unexpected", display_valid, 1'b0);
      else chk("display_value", display_value, disp_q.pop_front());
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", done, 1'b0);
      end else begin
        e = done_q.pop_front();
        n_done++;
        chk("done_latency", cyc - e.t, 3);
        chk("alu_param_at_done", alu_param, e.op);
        chk("display_valid_with_done", display_valid, e.op == 3'd7);
      end
    end
  end

  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {3'(op), 3'(rd), 3'(rs1), 3'(rs2), 4'b0};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rd, input int rs1, input int imm);
    return {3'(op), 3'(rd), 3'(rs1), 7'(imm)};
  endfunction

  function automatic logic [15:0] enc_ld(input int rd, input int imm);
    return {3'b000, 3'(rd), 10'(imm)};
  endfunction

  function automatic logic [15:0] enc_d(input int rs1);
    return {3'b111, 3'b000, 3'(rs1), 7'b0};
  endfunction

  // Offer one instruction and hold it until it is accepted. keep leaves
  // instr_valid high after the handshake. exp_wait >= 0 checks how many
  // cycles instr_ready stayed low before acceptance.
  task automatic send(input logic [15:0] w, input bit keep, input int exp_wait);
    int waited = 0;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (instr_ready !== 1'b1) begin
      chk("send_ready_timeout", instr_ready, 1'b1);
      instr_valid = 1'b0;
      return;
    end
    if (exp_wait >= 0) chk("ready_low_cycles", waited, exp_wait);
    model_issue(w, cyc);
    @(posedge clk);
    #1;
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    n_sent     -= done_q.size();
    done_q.delete();
    disp_q.delete();
    foreach (mregs[i]) mregs[i] = '0;
    repeat (2) @(negedge clk);
    chk("done_in_reset", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_instr_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_display_valid", display_valid, 1'b0);
    chk("rst_display_value", display_value, 16'h0);
    chk("rst_alu_a", alu_a, 16'h0);
    chk("rst_alu_b", alu_b, 16'h0);
    chk("rst_alu_param", alu_param, 3'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    bit keep;
    int guard;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    foreach (mregs[i]) mregs[i] = '0;
    do_reset();

    // LOAD R1,#5 then DISPLAY R1
    send(16'h0405, 1'b0, -1);
    send(16'hE080, 1'b0, -1);

    // ADD / SUB / MUL with a negative operand
    send(enc_ld(1, -3), 1'b0, -1);
    send(enc_ld(2, 7), 1'b0, -1);
    send(enc_r(1, 3, 1, 2), 1'b0, -1);
    send(enc_r(3, 4, 1, 2), 1'b0, -1);
    send(enc_r(5, 5, 1, 2), 1'b0, -1);
    send(enc_d(3), 1'b0, -1);
    send(enc_d(4), 1'b0, -1);
    send(enc_d(5), 1'b0, -1);

    // ADDI with the most negative imm7, SUBI wrapping from 0x8000
    send(enc_ld(1, 10), 1'b0, -1);
    send(enc_i(2, 1, 1, -64), 1'b0, -1);
    send(enc_d(1), 1'b0, -1);
    send(enc_ld(1, -512), 1'b0, -1);
    send(enc_ld(2, 64), 1'b0, -1);
    send(enc_r(5, 1, 1, 2), 1'b0, -1);
    send(enc_d(1), 1'b0, -1);
    send(enc_i(4, 1, 1, 1), 1'b0, -1);
    send(enc_d(1), 1'b0, -1);

    // MUL truncation 300*300
    send(enc_ld(1, 300), 1'b0, -1);
    send(enc_ld(2, 300), 1'b0, -1);
    send(enc_r(5, 3, 1, 2), 1'b0, -1);
    send(enc_d(3), 1'b0, -1);

    // instr_valid held high across instructions; rd == rs1 == rs2
    send(enc_ld(6, 123), 1'b1, -1);
    send(enc_r(1, 7, 6, 6), 1'b1, 3);
    send(enc_r(1, 7, 7, 7), 1'b1, 3);
    send(enc_d(7), 1'b0, 3);

    // Reset during EXEC of ADD R3
    send(enc_ld(1, 5), 1'b0, -1);
    send(enc_ld(2, 6), 1'b0, -1);
    send(enc_r(1, 3, 1, 2), 1'b0, -1);
    @(negedge clk);
    do_reset();
    send(enc_d(3), 1'b0, 0);

    // CLEAR after every register holds a nonzero value
    for (int i = 0; i < 8; i++) send(enc_ld(i, i + 1), 1'b0, -1);
    send(enc_d(7), 1'b0, -1);
    send(16'hC000, 1'b0, -1);
    for (int i = 0; i < 8; i++) send(enc_d(i), 1'b0, -1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 7);
      if (op == 6 && $urandom_range(0, 3) != 0) op = 7;
      keep = 1'($urandom_range(0, 1));
      send({3'(op), 13'($urandom)}, keep, -1);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    instr_valid = 1'b0;

    guard = 0;
    while (done_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("done_queue_drained", done_q.size(), 0);
    chk("display_queue_drained", disp_q.size(), 0);
    chk("done_count", n_done, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
